// File: rtl/im2col_x_loader.sv
// im2col_x_loader: walks the N x M im2col matrix in shared memory column by
// column, packs the N taps of each column into one wide vector and hands it
// to the systolic array X input over a valid/ready handshake.
module im2col_x_loader #(
    parameter int M          = 20,
    parameter int N          = 9,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] IM2COL_BASE = 32'h00002000,
    localparam int IDX_W     = (M > 1) ? $clog2(M) : 1,
    localparam int TAP_W     = (N > 1) ? $clog2(N) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    output logic [ADDR_WIDTH-1:0]   addr_rd,
    input  logic [DATA_WIDTH-1:0]   data_rd,
    output logic [DATA_WIDTH*N-1:0] x_out,
    output logic [IDX_W-1:0]        x_idx,
    output logic                    x_valid,
    input  logic                    x_ready,
    output logic                    busy,
    output logic                    done
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_LAST,
        ST_PRESENT,
        ST_DONE
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [TAP_W-1:0] n_q;
    logic [TAP_W-1:0] n_d;
    logic [IDX_W-1:0] m_q;
    logic [IDX_W-1:0] m_d;
    logic             cap_en;
    logic [TAP_W-1:0] cap_lane;

    // Element (n, m) lives at base + n*M + m; counters are zero whenever
    // the block is idle or finishing, so the address then rests on the base.
    assign addr_rd = IM2COL_BASE
                   + ADDR_WIDTH'(n_q) * ADDR_WIDTH'(M)
                   + ADDR_WIDTH'(m_q);

    assign x_idx = m_q;

    // State and tap/pixel counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            n_q     <= '0;
            m_q     <= '0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            m_q     <= m_d;
        end
    end

    // Next-state, counter updates, lane-capture control and status outputs.
    always_comb begin
        state_d  = state_q;
        n_d      = n_q;
        m_d      = m_q;
        cap_en   = 1'b0;
        cap_lane = '0;
        x_valid  = 1'b0;
        busy     = 1'b1;
        done     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_d = ST_FETCH;
                    n_d     = '0;
                    m_d     = '0;
                end
            end
            ST_FETCH: begin
                // The read issued on the previous cycle returns now and
                // belongs to the tap one behind the current address.
                if (n_q != '0) begin
                    cap_en   = 1'b1;
                    cap_lane = n_q - TAP_W'(1);
                end
                if (n_q == TAP_W'(N - 1)) begin
                    state_d = ST_LAST;
                end else begin
                    n_d = n_q + TAP_W'(1);
                end
            end
            ST_LAST: begin
                cap_en   = 1'b1;
                cap_lane = TAP_W'(N - 1);
                state_d  = ST_PRESENT;
            end
            ST_PRESENT: begin
                x_valid = 1'b1;
                if (x_ready) begin
                    n_d = '0;
                    if (m_q == IDX_W'(M - 1)) begin
                        m_d     = '0;
                        state_d = ST_DONE;
                    end else begin
                        m_d     = m_q + IDX_W'(1);
                        state_d = ST_FETCH;
                    end
                end
            end
            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                n_d     = '0;
                m_d     = '0;
            end
        endcase
    end

    // Vector register: lanes are overwritten in place and otherwise hold,
    // which keeps x_out stable for the whole time a vector is presented.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            x_out <= '0;
        end else if (cap_en) begin
            for (int i = 0; i < N; i++) begin
                if (cap_lane == TAP_W'(i)) begin
                    x_out[i*DATA_WIDTH +: DATA_WIDTH] <= data_rd;
                end
            end
        end
    end

endmodule

// File: tb/tb_im2col_x_loader.sv
// Testbench for im2col_x_loader: default 20x9 instance driven by scenario
// runs against a cycle-level reference model, plus a 1x1 instance driven by
// a per-cycle vector table.
module tb_im2col_x_loader;

    localparam int          M     = 20;
    localparam int          N     = 9;
    localparam int          DW    = 32;
    localparam int          AW    = 32;
    localparam int          CW    = DW * N;
    localparam int          IDX_W = 5;
    localparam logic [31:0] BASE  = 32'h00002000;
    localparam logic [31:0] SMALL_WORD = 32'hC0DE0001;
    localparam int          MAXC  = 2047;

    logic            clk;
    logic            rst;
    logic            start;
    logic [AW-1:0]   addr_rd;
    logic [DW-1:0]   data_rd;
    logic [CW-1:0]   x_out;
    logic [IDX_W-1:0] x_idx;
    logic            x_valid;
    logic            x_ready;
    logic            busy;
    logic            done;

    logic            s_start;
    logic [AW-1:0]   s_addr;
    logic [DW-1:0]   s_data;
    logic [DW-1:0]   s_xout;
    logic            s_idx;
    logic            s_valid;
    logic            s_ready;
    logic            s_busy;
    logic            s_done;

    int tests_run;
    int tests_failed;

    logic [31:0] mem_words [M*N];
    logic [31:0] exp_addr  [MAXC+1];
    bit          has_addr  [MAXC+1];

    typedef struct {
        logic start;
        logic ready;
        logic exp_valid;
        logic exp_busy;
        logic exp_done;
    } small_vec_t;

    small_vec_t small_tbl [14];

    im2col_x_loader #(
        .M(M), .N(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .IM2COL_BASE(BASE)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .addr_rd(addr_rd),
        .data_rd(data_rd), .x_out(x_out), .x_idx(x_idx), .x_valid(x_valid),
        .x_ready(x_ready), .busy(busy), .done(done)
    );

    im2col_x_loader #(
        .M(1), .N(1), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .IM2COL_BASE(BASE)
    ) dut_small (
        .clk(clk), .rst(rst), .start(s_start), .addr_rd(s_addr),
        .data_rd(s_data), .x_out(s_xout), .x_idx(s_idx), .x_valid(s_valid),
        .x_ready(s_ready), .busy(s_busy), .done(s_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_lookup(input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE;
        if (off < 32'(M * N)) return mem_words[int'(off)];
        return 32'hBAD00000;
    endfunction

    // Registered memories: data for an address appears one cycle later.
    always @(posedge clk) data_rd <= mem_lookup(addr_rd);
    always @(posedge clk) s_data  <= (s_addr == BASE) ? SMALL_WORD : 32'hBAD00000;

    function automatic logic [CW-1:0] expected_vector(input int m);
        logic [CW-1:0] v;
        v = '0;
        for (int n = 0; n < N; n++) v[n*DW +: DW] = mem_words[n*M + m];
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [CW-1:0] actual,
                               input logic [CW-1:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic fill_pattern();
        for (int n = 0; n < N; n++)
            for (int m = 0; m < M; m++)
                mem_words[n*M + m] = {16'h0000, 8'(n), 8'(m)};
    endtask

    task automatic fill_random();
        for (int i = 0; i < M*N; i++) mem_words[i] = $urandom;
    endtask

    task automatic check_reset_values(input string tag);
        checkOutput({tag, " x_valid"}, x_valid, 0);
        checkOutput({tag, " done"}, done, 0);
        checkOutput({tag, " busy"}, busy, 0);
        checkOutput({tag, " x_out"}, x_out, 0);
        checkOutput({tag, " x_idx"}, x_idx, 0);
        checkOutput({tag, " addr_rd"}, addr_rd, BASE);
    endtask

    // One cycle of the 1x1 instance: drive the row, then compare outputs.
    task automatic applyStimulus(input small_vec_t v, input int row);
        @(negedge clk);
        s_start = v.start;
        s_ready = v.ready;
        #1;
        checkOutput($sformatf("small row%0d x_valid", row), s_valid, v.exp_valid);
        checkOutput($sformatf("small row%0d busy", row), s_busy, v.exp_busy);
        checkOutput($sformatf("small row%0d done", row), s_done, v.exp_done);
        if (v.exp_valid) begin
            checkOutput($sformatf("small row%0d x_out", row), s_xout, SMALL_WORD);
            checkOutput($sformatf("small row%0d x_idx", row), s_idx, 0);
        end
    endtask

    // One full run of the 20x9 instance. The model derives every expected
    // event time from the per-pixel stall plan: pixel m is presented at
    // (m+1)(N+2) plus all earlier stalls, and its taps are fetched in the
    // N cycles starting right after the previous handshake.
    task automatic doRun(input string tag, input bit tie_ready, input int stall_pix,
                         input int stall_len, input bit rand_stall, input bit poke_start);
        int stalls [M];
        int pres_exp [M];
        int hs_exp [M];
        int acc, done_exp, hs_count, stall_left, done_seen, done_count;
        bit prev_valid, finished;

        for (int i = 0; i <= MAXC; i++) has_addr[i] = 1'b0;
        acc = 0;
        for (int m = 0; m < M; m++) begin
            stalls[m] = (m == stall_pix) ? stall_len :
                        (rand_stall ? int'($urandom_range(0, 3)) : 0);
            pres_exp[m] = (m + 1) * (N + 2) + acc;
            for (int n = 0; n < N; n++) begin
                exp_addr[m*(N+2) + acc + 1 + n] = BASE + 32'(n*M + m);
                has_addr[m*(N+2) + acc + 1 + n] = 1'b1;
            end
            acc += stalls[m];
            hs_exp[m] = pres_exp[m] + stalls[m];
        end
        done_exp = M * (N + 2) + 1 + acc;

        @(negedge clk);
        start   = 1'b1;
        x_ready = tie_ready ? 1'b1 : 1'($urandom_range(0, 1));
        #1;
        checkOutput({tag, " cycle0 busy"}, busy, 0);
        checkOutput({tag, " cycle0 addr_rd"}, addr_rd, BASE);

        hs_count = 0; stall_left = 0; done_seen = -1; done_count = 0;
        prev_valid = 1'b0; finished = 1'b0;
        for (int k = 1; k <= done_exp + 20 && !finished; k++) begin
            @(negedge clk);
            start = (poke_start && busy && !done) ? 1'($urandom_range(0, 1)) : 1'b0;
            if (has_addr[k])
                checkOutput($sformatf("%s addr cycle%0d", tag, k), addr_rd, exp_addr[k]);
            if (x_valid && hs_count < M) begin
                if (!prev_valid) begin
                    checkOutput($sformatf("%s present cycle m%0d", tag, hs_count), k, pres_exp[hs_count]);
                    stall_left = stalls[hs_count];
                end
                checkOutput($sformatf("%s x_out m%0d cycle%0d", tag, hs_count, k), x_out, expected_vector(hs_count));
                checkOutput($sformatf("%s x_idx cycle%0d", tag, k), x_idx, hs_count);
                checkOutput($sformatf("%s addr hold cycle%0d", tag, k), addr_rd,
                            BASE + 32'((N-1)*M + hs_count));
                x_ready = (stall_left == 0);
                if (stall_left > 0) stall_left--;
                if (x_ready) begin
                    checkOutput($sformatf("%s handshake cycle m%0d", tag, hs_count), k, hs_exp[hs_count]);
                    hs_count++;
                end
            end else begin
                x_ready = tie_ready ? 1'b1 : 1'($urandom_range(0, 1));
            end
            prev_valid = x_valid;
            if (done) begin
                done_count++;
                done_seen = k;
            end
            if (k == done_exp) begin
                checkOutput({tag, " busy at done"}, busy, 1);
                checkOutput({tag, " addr at done"}, addr_rd, BASE);
            end
            if (k == done_exp + 1) begin
                checkOutput({tag, " busy after done"}, busy, 0);
                checkOutput({tag, " done after done"}, done, 0);
                checkOutput({tag, " addr idle"}, addr_rd, BASE);
                finished = 1'b1;
            end
        end
        start = 1'b0;
        checkOutput({tag, " handshake count"}, hs_count, M);
        checkOutput({tag, " done cycle"}, done_seen, done_exp);
        checkOutput({tag, " done pulses"}, done_count, 1);
    endtask

    // Assert reset in the middle of a run, between clock edges.
    task automatic midReset();
        @(negedge clk);
        start   = 1'b1;
        x_ready = 1'b1;
        for (int k = 1; k <= 50; k++) begin
            @(negedge clk);
            start = 1'b0;
        end
        #2 rst = 1'b0;
        #1 check_reset_values("async reset");
        repeat (2) @(negedge clk);
        checkOutput("in reset done", done, 0);
        checkOutput("in reset busy", busy, 0);
        rst = 1'b1;
    endtask

    // start held high: back-to-back runs separated by one IDLE cycle.
    task automatic continuousStart();
        int d, d1, d2, done_count;
        d = M * (N + 2) + 1;
        d1 = -1; d2 = -1; done_count = 0;
        @(negedge clk);
        start   = 1'b1;
        x_ready = 1'b1;
        for (int k = 1; k <= 2*d + 3; k++) begin
            @(negedge clk);
            if (k == 2*d + 2) start = 1'b0;
            if (done) begin
                done_count++;
                if (d1 < 0) d1 = k; else d2 = k;
            end
            if (k == d + 1) begin
                checkOutput("cont done width", done, 0);
                checkOutput("cont idle gap busy", busy, 0);
            end
            if (k == d + 2) checkOutput("cont second run busy", busy, 1);
            if (k == 2*d + 2) checkOutput("cont second idle busy", busy, 0);
            if (k == 2*d + 3) checkOutput("cont stopped busy", busy, 0);
        end
        checkOutput("cont first done", d1, d);
        checkOutput("cont second done", d2, 2*d + 1);
        checkOutput("cont done pulses", done_count, 2);
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst     = 1'b0;
        start   = 1'b0;
        x_ready = 1'b0;
        s_start = 1'b0;
        s_ready = 1'b0;
        fill_pattern();

        small_tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        small_tbl[1]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        small_tbl[2]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        small_tbl[3]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        small_tbl[4]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        small_tbl[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        small_tbl[6]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        small_tbl[7]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        small_tbl[8]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        small_tbl[9]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        small_tbl[10] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        small_tbl[11] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        small_tbl[12] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        small_tbl[13] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

        repeat (2) @(negedge clk);
        #1 check_reset_values("reset held");
        @(negedge clk);
        rst = 1'b1;
        #1 check_reset_values("reset released");

        for (int i = 0; i < 14; i++) applyStimulus(small_tbl[i], i);

        doRun("nominal", 1'b1, -1, 0, 1'b0, 1'b0);
        doRun("stall m3", 1'b1, 3, 5, 1'b0, 1'b0);
        midReset();
        doRun("after reset", 1'b1, -1, 0, 1'b0, 1'b0);
        fill_random();
        doRun("random1", 1'b0, -1, 0, 1'b1, 1'b1);
        doRun("random2", 1'b0, 0, 2, 1'b1, 1'b1);
        fill_pattern();
        continuousStart();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/im2col_x_loader.md
# im2col_x_loader

Streams the im2col matrix from shared memory into the systolic array's X input. Sits between `im2col` and `systolic_array`. On `start` it reads the M×N im2col matrix column by column through the single read port. It packs each column's N taps into one `DATA_WIDTH*N` vector and presents it with a valid/ready handshake, one vector per output pixel. It pulses `done` after the M-th vector is accepted.

## Interface
- `M`, default 20: number of output pixels (`IMG_H*IMG_W`), i.e. vectors per run.
- `N`, default 9: taps per vector (`FILTER_SIZE*FILTER_SIZE`).
- `DATA_WIDTH`, default 32: element width.
- `ADDR_WIDTH`, default 32: memory address width.
- `IM2COL_BASE`, default 32'h00002000: word address of element (n=0, m=0).
- `clk`, input, 1: the single clock; all logic on rising edge.
- `rst`, input, 1: asynchronous, active-low reset. Asserting it (0) immediately forces reset state.
- `start`, input, 1: run request, sampled only in IDLE.
- `addr_rd`, output, ADDR_WIDTH: memory read address.
- `data_rd`, input, DATA_WIDTH: memory read data, valid the cycle after `addr_rd` is presented (registered memory).
- `x_out`, output, DATA_WIDTH*N: packed vector; tap n in bits `[n*DATA_WIDTH +: DATA_WIDTH]`.
- `x_idx`, output, clog2(M) (min 1): pixel index m of `x_out`.
- `x_valid`, output, 1: `x_out`/`x_idx` valid.
- `x_ready`, input, 1: consumer accepts when high with `x_valid`.
- `busy`, output, 1: high in every state except IDLE.
- `done`, output, 1: one-cycle pulse after the last handshake.

## Operation
- Memory layout is N rows × M columns, row-major. Element (n, m) sits at `IM2COL_BASE + n*M + m`. Address arithmetic is in ADDR_WIDTH bits, modulo 2^ADDR_WIDTH.
- `addr_rd` is combinational from counters n and m: `IM2COL_BASE + n*M + m`. In IDLE, DONE and reset it equals `IM2COL_BASE` (n=m=0).
- States and transitions:
  - IDLE: `start`=1 → FETCH; m=0, n=0.
  - FETCH: present the address for (n, m) each cycle. When n≥1, capture `data_rd` into lane n-1. If n==N-1 → LAST; else n++.
  - LAST: capture `data_rd` into lane N-1; → PRESENT.
  - PRESENT: `x_valid`=1, `x_idx`=m.
    - On `x_ready`=1 with m==M-1 → DONE.
    - On `x_ready`=1 with m<M-1: m++, n=0 → FETCH.
    - Otherwise stay.
  - DONE: `done`=1 for exactly one cycle → IDLE.
- `x_out` is a register. It only changes by lane capture in FETCH/LAST and holds stable throughout PRESENT, including any stall.
- Lanes are overwritten in place; no clearing between vectors.
- `start` outside IDLE is ignored. `start` held high in DONE does not matter: the next run starts from IDLE on a later cycle.
- `x_ready` outside PRESENT is ignored.
- N=1: FETCH lasts one cycle, then LAST captures lane 0.
- M=1: the first accepted vector leads to DONE.

## Timing
- Reset values: `x_valid`=0, `done`=0, `busy`=0, `x_out`=0, `x_idx`=0, `addr_rd`=`IM2COL_BASE`, state IDLE.
- Reset mid-run: asynchronous return to the reset state. Any partial vector is discarded, no `done` is produced, and the next `start` begins again at m=0.
- Cycle 0 = the IDLE cycle in which `start`=1.
  - FETCH occupies cycles 1..N and LAST is cycle N+1.
  - The first `x_valid` appears in cycle N+2.
- With `x_ready` tied high:
  - Each vector takes N+2 cycles.
  - The handshake for pixel m occurs in cycle (m+1)(N+2).
  - `done` pulses in cycle M(N+2)+1, and `busy` drops in the following cycle.
- Every stall cycle in PRESENT delays all later events by exactly one cycle.
- Exactly one memory read is issued per FETCH cycle and none in other states. Total reads per run = M*N.

## Test plan
- Memory word (n, m) = `{n[7:0], m[7:0]}`, M=20, N=9, `x_ready`=1, `start` pulse at cycle 0.
  - Required: first `x_valid` at cycle 11 with lane n = `16'h0n00`, `x_idx`=0.
  - Required: vector m=19 has lane n = `{n, 8'h13}`, handshake at cycle 220.
  - Required: `done` is high only in cycle 221.
- Same setup, `x_ready` low for 5 cycles on m=3.
  - Required: `x_out`/`x_idx` stable while stalled.
  - Required: `done` moves to cycle 226; no reads are issued during the stall.
- `addr_rd` trace over the first two vectors.
  - Required: 0x2000, 0x2014, 0x2028 … 0x20A0, then 0x2001, 0x2015, ….
- Drive `rst` low at cycle 50 of a run, release it, and pulse `start` again.
  - Required: outputs return to reset values asynchronously.
  - Required: the new run restarts at m=0 and completes with the same timing as scenario 1.
- Pulse `start` while busy.
  - Required: no effect.
- Hold `start` high continuously.
  - Required: back-to-back runs, each `done` exactly one cycle, next FETCH begins ≥2 cycles after `done`.
- Degenerate configuration M=1, N=1.
  - Required: `x_valid` at cycle 3, `done` at cycle 4.
